mem_write_monitor: RTL and testbench
====================================

# mem_write_monitor

Synthesizable, parametrised self-check unit that snoops the processor's data-memory write port and decides pass/fail on-chip. It generalises the fixed "value 7 lands at address 100, writes to 96 are tolerated" bench check to CH expected (address, data) pairs, a tolerated scratch address window and a cycle timeout. It sits beside the data memory in `top`, in simulation or on FPGA, and drives status LEDs or a bench `$stop`.

## Interface
- `N`, 32, data width
- `AW`, 32, address width
- `CH`, 2, number of expected-write channels (≥1)
- `TW`, 16, timeout counter width
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; latches the configuration and arms the monitor
- `exp_addr`  in  CH*AW  expected address per channel; channel i occupies bits [i*AW +: AW]
- `exp_data`  in  CH*N  expected data per channel; channel i occupies bits [i*N +: N]
- `scratch_lo`, `scratch_hi`  in  AW each  tolerated write window, inclusive
- `timeout`  in  TW  cycle limit; 0 disables the timeout
- `mem_we`  in  1  memory write strobe
- `mem_addr`  in  AW  write address
- `mem_wdata`  in  N  write data
- `done`  out  1  high in PASS or FAIL
- `pass`  out  1  high in PASS
- `fail_code`  out  2  0 none, 1 data mismatch, 2 stray write, 3 timeout
- `match_mask`  out  CH  per-channel matched flags
- `write_count`  out  16  writes seen in RUN, saturating at 16'hFFFF

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: monitor ignores writes. `start` latches all config inputs, clears the mask, counters and fail_code, then enters RUN.
- RUN, on each cycle with `mem_we`=1, checks in this priority:
  - Address equals a channel's `exp_addr`. If several channels share the address, the lowest index wins. Data equal sets that channel's mask bit. Data unequal goes to FAIL with code 1, including a rewrite of an already-matched channel.
  - Otherwise, address within [scratch_lo, scratch_hi]: the write is tolerated and only counted. `scratch_lo > scratch_hi` means an empty window.
  - Otherwise: FAIL with code 2.
- Every write seen in RUN increments `write_count`, including the write that causes FAIL.
- All mask bits set after the current update: go to PASS.
- Timeout: the cycle counter counts RUN cycles starting at 1 on the first RUN cycle. When the counter equals `timeout` (≠0) and PASS is not reached that cycle, go to FAIL with code 3.
- Precedence within one cycle: data mismatch > stray write > PASS completion > timeout. A completing match on the timeout cycle yields PASS.
- PASS and FAIL are sticky. `start` there re-arms, same as from IDLE. `start` in RUN is ignored.
- `reset` in any state, including mid-RUN, returns to IDLE and zeroes every output and counter.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency: a write sampled at edge k updates `match_mask`, `write_count`, `done`, `pass` and `fail_code` after edge k. They are visible in cycle k+1.
- `start` at edge k puts the monitor in RUN from cycle k+1. A write coincident with `start` is not evaluated.
- Timeout fires at edge number `timeout` after arming, counting RUN cycles. `done` is high the following cycle.
- No handshake on the snoop port. The monitor never back-pressures the memory.

## Structure
- Package `mem_monitor_pkg`:
  - `state_t` enum (IDLE, RUN, PASS, FAIL)
  - `fail_t` enum (`FAIL_NONE`, `FAIL_DATA`, `FAIL_STRAY`, `FAIL_TIMEOUT`, 2-bit)
- Sub-module `monitor_channel`, instanced CH times via generate:
  - holds the latched addr/data and the matched flag
  - outputs `hit`, `data_ok` and `matched`
- The top level does the lowest-index priority, the FSM and the counters.

## Test plan
- CH=1, exp 100/7, scratch 96..96, timeout 0. Write 96←3, then 100←7. Expect `write_count`=2, `pass`=1 and `done`=1 one cycle after the second write, `fail_code`=0.
- Same config, write 100←5. Expect next cycle `done`=1, `pass`=0, `fail_code`=1, `match_mask`=0.
- Same config, write 80←7. Expect `fail_code`=2. Then pulse `start` and write 100←7. Expect PASS, with `write_count`=1 after the re-arm.
- CH=2, exp 100/7 and 104/9, timeout 20. Write 104←9 at RUN cycle 5; `match_mask`=2'b10 and still RUN. With no further writes, expect `fail_code`=3 after RUN cycle 20. Repeat the run with 100←7 sampled on RUN cycle 20: expect PASS, not timeout.
- CH=2 with both channels at exp 100/7. A single write 100←7 sets only `match_mask`=2'b01 and the monitor stays in RUN.
- Reset asserted mid-RUN with `match_mask`=2'b01. Expect all outputs 0 and state IDLE next cycle. Writes in IDLE leave `write_count` at 0.

Source files
------------

// File: rtl/mem_monitor_pkg.sv
// Shared types for the data-memory write monitor: FSM states and failure codes.
package mem_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    FAIL_NONE,
    FAIL_DATA,
    FAIL_STRAY,
    FAIL_TIMEOUT
  } fail_t;

  localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/monitor_channel.sv
// One expected-write channel: holds the armed address/data pair and its matched flag.
module monitor_channel #(
  parameter int N  = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          set_match,
  input  logic [AW-1:0] cfg_addr,
  input  logic [N-1:0]  cfg_data,
  input  logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_wdata,
  output logic          hit,
  output logic          data_ok,
  output logic          matched
);

  logic [AW-1:0] addr_q;
  logic [N-1:0]  data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      matched <= 1'b0;
    end else if (load) begin
      addr_q  <= cfg_addr;
      data_q  <= cfg_data;
      matched <= 1'b0;
    end else if (set_match) begin
      matched <= 1'b1;
    end
  end

  assign hit     = (mem_addr == addr_q);
  assign data_ok = (mem_wdata == data_q);

endmodule

// File: rtl/mem_write_monitor.sv
// Snoops the data-memory write port and decides pass/fail against CH expected
// (address, data) pairs, a tolerated scratch window and an optional cycle timeout.
module mem_write_monitor
  import mem_monitor_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 32,
  parameter int CH = 2,
  parameter int TW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CH*AW-1:0]    exp_addr,
  input  logic [CH*N-1:0]     exp_data,
  input  logic [AW-1:0]       scratch_lo,
  input  logic [AW-1:0]       scratch_hi,
  input  logic [TW-1:0]       timeout,
  input  logic                mem_we,
  input  logic [AW-1:0]       mem_addr,
  input  logic [N-1:0]        mem_wdata,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_code,
  output logic [CH-1:0]       match_mask,
  output logic [COUNT_W-1:0]  write_count
);

  state_t               state_q, state_d;
  fail_t                fail_q, fail_d;
  logic                 done_q, pass_q;
  logic [COUNT_W-1:0]   cnt_q;
  logic [TW-1:0]        cyc_q;
  logic [TW-1:0]        to_q;
  logic [AW-1:0]        lo_q, hi_q;

  logic                 load;
  logic                 found;
  logic                 bad_data;
  logic                 in_scratch;
  logic [CH-1:0]        hit, data_ok, matched, set_vec;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    monitor_channel #(.N(N), .AW(AW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .set_match (set_vec[i]),
      .cfg_addr  (exp_addr[i*AW +: AW]),
      .cfg_data  (exp_data[i*N +: N]),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .hit       (hit[i]),
      .data_ok   (data_ok[i]),
      .matched   (matched[i])
    );
  end

  // An inverted window (lo > hi) can never satisfy both bounds, so it is empty.
  assign in_scratch = (mem_addr >= lo_q) && (mem_addr <= hi_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    set_vec  = '0;
    load     = 1'b0;
    found    = 1'b0;
    bad_data = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_we) begin
          for (int i = 0; i < CH; i++) begin
            if (!found && hit[i]) begin
              found = 1'b1;
              if (data_ok[i]) set_vec[i] = 1'b1;
              else            bad_data   = 1'b1;
            end
          end
        end
        if (bad_data) begin
          state_d = FAIL;
          fail_d  = FAIL_DATA;
        end else if (mem_we && !found && !in_scratch) begin
          state_d = FAIL;
          fail_d  = FAIL_STRAY;
        end else if ((matched | set_vec) == '1) begin
          state_d = PASS;
        end else if (to_q != '0 && cyc_q == to_q) begin
          state_d = FAIL;
          fail_d  = FAIL_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
          fail_d  = FAIL_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fail_q  <= FAIL_NONE;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      to_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      done_q  <= (state_d == PASS) || (state_d == FAIL);
      pass_q  <= (state_d == PASS);
      if (load) begin
        cnt_q <= '0;
        cyc_q <= TW'(1);
        to_q  <= timeout;
        lo_q  <= scratch_lo;
        hi_q  <= scratch_hi;
      end else if (state_q == RUN) begin
        cyc_q <= cyc_q + TW'(1);
        if (mem_we && cnt_q != '1) cnt_q <= cnt_q + COUNT_W'(1);
      end
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_q;
  assign match_mask  = matched;
  assign write_count = cnt_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: one CH=1 and one CH=2 instance on a shared snoop bus.
module tb_mem_write_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] scratch_lo = 32'd96;
  logic [31:0] scratch_hi = 32'd96;

  logic        start1 = 1'b0;
  logic [31:0] exp_addr1 = 32'd100;
  logic [31:0] exp_data1 = 32'd7;
  logic [15:0] timeout1 = 16'd0;
  logic        done1, pass1;
  logic [1:0]  fc1;
  logic [0:0]  mask1;
  logic [15:0] cnt1;

  logic        start2 = 1'b0;
  logic [63:0] exp_addr2 = {32'd104, 32'd100};
  logic [63:0] exp_data2 = {32'd9, 32'd7};
  logic [15:0] timeout2 = 16'd20;
  logic        done2, pass2;
  logic [1:0]  fc2;
  logic [1:0]  mask2;
  logic [15:0] cnt2;

  always #5 clk = ~clk;

  mem_write_monitor #(.N(32), .AW(32), .CH(1), .TW(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .exp_addr(exp_addr1), .exp_data(exp_data1),
    .scratch_lo(scratch_lo), .scratch_hi(scratch_hi), .timeout(timeout1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done1), .pass(pass1), .fail_code(fc1),
    .match_mask(mask1), .write_count(cnt1)
  );

  mem_write_monitor #(.N(32), .AW(32), .CH(2), .TW(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .exp_addr(exp_addr2), .exp_data(exp_data2),
    .scratch_lo(scratch_lo), .scratch_hi(scratch_hi), .timeout(timeout2),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done2), .pass(pass2), .fail_code(fc2),
    .match_mask(mask2), .write_count(cnt2)
  );

  typedef struct {
    bit          which;
    string       tag;
    logic        done;
    logic        pass;
    logic [1:0]  fc;
    logic [1:0]  mask;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic arm(input bit which);
    if (which) start2 = 1'b1;
    else       start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic expect_out(input bit which, input string tag, input logic d, input logic p,
                            input logic [1:0] fc, input logic [1:0] m, input logic [15:0] c);
    exp_t e;
    e.which = which; e.tag = tag; e.done = d; e.pass = p;
    e.fc = fc; e.mask = m; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.which) begin
        check({e.tag, ".done"}, {31'b0, done2}, {31'b0, e.done});
        check({e.tag, ".pass"}, {31'b0, pass2}, {31'b0, e.pass});
        check({e.tag, ".fail_code"}, {30'b0, fc2}, {30'b0, e.fc});
        check({e.tag, ".mask"}, {30'b0, mask2}, {30'b0, e.mask});
        check({e.tag, ".count"}, {16'b0, cnt2}, {16'b0, e.cnt});
      end else begin
        check({e.tag, ".done"}, {31'b0, done1}, {31'b0, e.done});
        check({e.tag, ".pass"}, {31'b0, pass1}, {31'b0, e.pass});
        check({e.tag, ".fail_code"}, {30'b0, fc1}, {30'b0, e.fc});
        check({e.tag, ".mask"}, {31'b0, mask1}, {30'b0, e.mask});
        check({e.tag, ".count"}, {16'b0, cnt1}, {16'b0, e.cnt});
      end
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    expect_out(0, "rst1", 0, 0, 2'd0, 2'b00, 16'd0);
    expect_out(1, "rst2", 0, 0, 2'd0, 2'b00, 16'd0);
    compare_out();
    reset = 1'b0;
    tick();

    // CH=1: scratch write then the expected write
    arm(0);
    expect_out(0, "t1_armed", 0, 0, 2'd0, 2'b00, 16'd0);
    compare_out();
    expect_out(0, "t1_scratch", 0, 0, 2'd0, 2'b00, 16'd1);
    wr(32'd96, 32'd3);
    compare_out();
    expect_out(0, "t1_pass", 1, 1, 2'd0, 2'b01, 16'd2);
    wr(32'd100, 32'd7);
    compare_out();
    expect_out(0, "t1_sticky", 1, 1, 2'd0, 2'b01, 16'd2);
    wr(32'd80, 32'd1);
    compare_out();

    // Re-arm from PASS with a coincident stray write that must be ignored
    mem_we = 1'b1; mem_addr = 32'd80; mem_wdata = 32'd7;
    expect_out(0, "t2_arm_coinc", 0, 0, 2'd0, 2'b00, 16'd0);
    arm(0);
    mem_we = 1'b0;
    compare_out();
    expect_out(0, "t2_bad_data", 1, 0, 2'd1, 2'b00, 16'd1);
    wr(32'd100, 32'd5);
    compare_out();

    // Stray write, then re-arm and pass
    arm(0);
    expect_out(0, "t3_stray", 1, 0, 2'd2, 2'b00, 16'd1);
    wr(32'd80, 32'd7);
    compare_out();
    arm(0);
    expect_out(0, "t3_rearm", 0, 0, 2'd0, 2'b00, 16'd0);
    compare_out();
    expect_out(0, "t3_pass", 1, 1, 2'd0, 2'b01, 16'd1);
    wr(32'd100, 32'd7);
    compare_out();

    // CH=2, timeout 20: match ch1 on RUN cycle 5, then time out at cycle 20
    arm(1);
    idle(4);
    expect_out(1, "t4_ch1", 0, 0, 2'd0, 2'b10, 16'd1);
    wr(32'd104, 32'd9);
    compare_out();
    expect_out(1, "t4_cyc19", 0, 0, 2'd0, 2'b10, 16'd1);
    idle(14);
    compare_out();
    expect_out(1, "t4_timeout", 1, 0, 2'd3, 2'b10, 16'd1);
    idle(1);
    compare_out();

    // Completion on the timeout cycle wins
    arm(1);
    idle(4);
    wr(32'd104, 32'd9);
    idle(14);
    expect_out(1, "t4b_pass_at_to", 1, 1, 2'd0, 2'b11, 16'd2);
    wr(32'd100, 32'd7);
    compare_out();

    // Both channels on the same address: lowest index wins
    exp_addr2 = {32'd100, 32'd100};
    exp_data2 = {32'd7, 32'd7};
    timeout2  = 16'd0;
    arm(1);
    expect_out(1, "t5_low_idx", 0, 0, 2'd0, 2'b01, 16'd1);
    wr(32'd100, 32'd7);
    compare_out();
    expect_out(1, "t5_still_run", 0, 0, 2'd0, 2'b01, 16'd1);
    idle(2);
    compare_out();

    // Reset mid-RUN, then writes in IDLE are ignored
    reset = 1'b1;
    expect_out(1, "t6_rst2", 0, 0, 2'd0, 2'b00, 16'd0);
    expect_out(0, "t6_rst1", 0, 0, 2'd0, 2'b00, 16'd0);
    tick();
    compare_out();
    reset = 1'b0;
    expect_out(1, "t6_idle_wr", 0, 0, 2'd0, 2'b00, 16'd0);
    wr(32'd100, 32'd7);
    compare_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
